seg_scan_driver: RTL and testbench

Time-multiplexed six-digit seven-segment scan driver that sits directly downstream of the 24-hour counter. It consumes the counter's packed 42-bit segment bus (digit k in bits [7k+6:7k], digit 0 = seconds ones) and drives one shared segment bus plus six digit-select lines. Each digit gets its own time slot, and anti-ghosting blanking is inserted at the start of every slot. Per-digit blinking is supported for time-set indication.

---
 rtl/seg_scan_driver.sv | 119 +++++++++++
 tb/tb_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Six-digit seven-segment scan driver: one slot per digit, blanked slot head,
// per-digit blink. All outputs are registered.
module seg_scan_driver #(
   parameter int                     led_num      = 6,
   parameter int                     segment_num  = 7,
   parameter int                     DIGIT_CYCLES = 8333,
   parameter int                     BLANK_CYCLES = 64,
   parameter int                     BLINK_CYCLES = 12500000,
   parameter logic [segment_num-1:0] SEG_OFF      = 7'h7F
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [led_num*segment_num-1:0] seg_in,
   input  logic [led_num-1:0]             blink_mask,
   output logic [segment_num-1:0]         seg_out,
   output logic [led_num-1:0]             dig_sel,
   output logic                           frame_tick
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IW = (led_num > 1) ? $clog2(led_num) : 1;
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(led_num - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
   logic                   blink_phase_q, blink_phase_d;
   logic [segment_num-1:0] snap_q, snap_d;
   logic [segment_num-1:0] seg_out_q, seg_out_d;
   logic [led_num-1:0]     dig_sel_q, dig_sel_d;
   logic                   frame_tick_q, frame_tick_d;

   logic [segment_num-1:0] sel_seg;
   logic [led_num-1:0]     sel_onehot;
   logic                   sel_blink;

   // Decode the current digit index once; reused for snapshot, select and blink.
   always_comb begin
      sel_seg    = SEG_OFF;
      sel_onehot = '0;
      sel_blink  = 1'b0;
      for (int k = 0; k < led_num; k++) begin
         if (idx_q == IW'(k)) begin
            sel_seg       = seg_in[k*segment_num +: segment_num];
            sel_onehot[k] = 1'b1;
            sel_blink     = blink_mask[k];
         end
      end
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end

      cnt_d        = '0;
      idx_d        = '0;
      snap_d       = snap_q;
      seg_out_d    = SEG_OFF;
      dig_sel_d    = '0;
      frame_tick_d = 1'b0;

      if (enable) begin
         idx_d = idx_q;
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end

         // Pattern is frozen at slot start so a mid-slot seg_in change cannot tear.
         if (cnt_q == '0) snap_d = sel_seg;

         if (cnt_q >= BLANK_END) begin
            dig_sel_d = sel_onehot;
            seg_out_d = (blink_phase_q && sel_blink) ? SEG_OFF : snap_q;
         end

         frame_tick_d = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         snap_q        <= SEG_OFF;
         seg_out_q     <= SEG_OFF;
         dig_sel_q     <= '0;
         frame_tick_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_q        <= snap_d;
         seg_out_q     <= seg_out_d;
         dig_sel_q     <= dig_sel_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign seg_out    = seg_out_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with short slots (8 cycles, 2 blanked,
// 20-cycle blink half-period).
module tb_seg_scan_driver;

   localparam int LN = 6;
   localparam int SN = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [LN*SN-1:0]  seg_in;
   logic [LN-1:0]     blink_mask;
   logic [SN-1:0]     seg_out;
   logic [LN-1:0]     dig_sel;
   logic              frame_tick;

   int n_assert = 0;
   int n_fail   = 0;

   // st: scan position of the next edge; bl: non-reset edges since reset.
   int st  = 0;
   int bl  = 0;
   int cyc = 0;
   logic [SN-1:0] snap_m  = 7'h7F;
   logic [LN-1:0] exp_dig;
   logic [SN-1:0] exp_seg;
   logic          exp_ft;

   seg_scan_driver #(
      .led_num(LN), .segment_num(SN), .DIGIT_CYCLES(8), .BLANK_CYCLES(2),
      .BLINK_CYCLES(20), .SEG_OFF(7'h7F)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .seg_in(seg_in),
      .blink_mask(blink_mask), .seg_out(seg_out), .dig_sel(dig_sel),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic tick();
      int c, i, ph;
      c  = st % 8;
      i  = (st / 8) % 6;
      ph = (bl / 20) % 2;
      if (rst) begin
         exp_dig = '0; exp_seg = 7'h7F; exp_ft = 1'b0; snap_m = 7'h7F;
      end else if (!enable) begin
         exp_dig = '0; exp_seg = 7'h7F; exp_ft = 1'b0;
      end else begin
         if (c == 0) snap_m = seg_in[i*SN +: SN];
         exp_dig = (c < 2) ? '0 : LN'(1 << i);
         exp_seg = (c < 2) ? 7'h7F : ((ph == 1 && blink_mask[i]) ? 7'h7F : snap_m);
         exp_ft  = (c == 7) && (i == 5);
      end
      @(posedge clk); #1;
      if (rst) begin st = 0; bl = 0; end
      else begin bl++; st = enable ? st + 1 : 0; end
      cyc++;
   endtask

   task automatic test_reset();
      logic [LN-1:0] ed;
      logic [SN-1:0] es;
      rst = 1'b1; enable = 1'b1; blink_mask = '0;
      seg_in = {7'h24, 7'h02, 7'h12, 7'h30, 7'h79, 7'h40};
      for (int k = 0; k < 3; k++) begin
         tick();
         n_assert += 3;
         if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL reset seg_out: got %h expected 7f", seg_out); end
         if (dig_sel !== '0) begin n_fail++; $display("FAIL reset dig_sel: got %b expected 000000", dig_sel); end
         if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset frame_tick: got %b expected 0", frame_tick); end
      end
      rst = 1'b0;
      for (int k = 0; k < 11; k++) begin
         tick();
         ed = (k < 2 || k == 8 || k == 9) ? 6'b000000 : ((k < 8) ? 6'b000001 : 6'b000010);
         es = (k >= 2 && k < 8) ? 7'h40 : ((k == 10) ? 7'h79 : 7'h7F);
         n_assert += 2;
         if (dig_sel !== ed) begin n_fail++; $display("FAIL startup dig_sel k=%0d: got %b expected %b", k, dig_sel, ed); end
         if (seg_out !== es) begin n_fail++; $display("FAIL startup seg_out k=%0d: got %h expected %h", k, seg_out, es); end
      end
   endtask

   task automatic test_routing();
      logic [SN-1:0] es;
      for (int k = 0; k < 96; k++) begin
         tick();
         es = 7'h00;
         case (dig_sel)
            6'b000000: es = 7'h7F;
            6'b000001: es = 7'h40;
            6'b000010: es = 7'h79;
            6'b000100: es = 7'h30;
            6'b001000: es = 7'h12;
            6'b010000: es = 7'h02;
            6'b100000: es = 7'h24;
            default:   es = 7'h00;
         endcase
         n_assert += 4;
         if (seg_out !== es) begin n_fail++; $display("FAIL routing pattern: got %h expected %h with dig_sel %b", seg_out, es, dig_sel); end
         if (dig_sel !== exp_dig) begin n_fail++; $display("FAIL routing dig_sel: got %b expected %b", dig_sel, exp_dig); end
         if (seg_out !== exp_seg) begin n_fail++; $display("FAIL routing seg_out: got %h expected %h", seg_out, exp_seg); end
         if (frame_tick !== exp_ft) begin n_fail++; $display("FAIL routing frame_tick: got %b expected %b", frame_tick, exp_ft); end
      end
   endtask

   task automatic test_snapshot();
      int guard;
      guard = 0;
      while (st % 48 != 20 && guard < 100) begin tick(); guard++; end
      n_assert++;
      if (st % 48 != 20) begin n_fail++; $display("FAIL snapshot position: got %0d expected 20", st % 48); end
      seg_in[2*SN +: SN] = 7'h19;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_assert += 2;
         if (dig_sel !== 6'b000100) begin n_fail++; $display("FAIL snapshot dig_sel: got %b expected 000100", dig_sel); end
         if (seg_out !== 7'h30) begin n_fail++; $display("FAIL snapshot held: got %h expected 30", seg_out); end
      end
      guard = 0;
      tick();
      while (dig_sel !== 6'b000100 && guard < 60) begin tick(); guard++; end
      n_assert += 2;
      if (dig_sel !== 6'b000100) begin n_fail++; $display("FAIL snapshot revisit: got %b expected 000100", dig_sel); end
      if (seg_out !== 7'h19) begin n_fail++; $display("FAIL snapshot new frame: got %h expected 19", seg_out); end
   endtask

   task automatic test_frame_tick();
      int last, pulses;
      logic prev_ft;
      last = -1; pulses = 0; prev_ft = 1'b0;
      for (int k = 0; k < 144; k++) begin
         tick();
         n_assert += 3;
         if (!$onehot0(dig_sel)) begin n_fail++; $display("FAIL frame onehot: got %b expected at most one bit", dig_sel); end
         if (frame_tick !== exp_ft) begin n_fail++; $display("FAIL frame_tick model: got %b expected %b", frame_tick, exp_ft); end
         if (prev_ft && frame_tick) begin n_fail++; $display("FAIL frame_tick width: got 2 expected 1"); end
         if (frame_tick === 1'b1) begin
            pulses++;
            if (last >= 0) begin
               n_assert++;
               if (cyc - last != 48) begin n_fail++; $display("FAIL frame period: got %0d expected 48", cyc - last); end
            end
            last = cyc;
         end
         prev_ft = frame_tick;
      end
      n_assert++;
      if (pulses != 3) begin n_fail++; $display("FAIL frame count: got %0d expected 3", pulses); end
   endtask

   task automatic test_blink();
      int dark_hits, lit_hits;
      dark_hits = 0; lit_hits = 0;
      blink_mask = 6'b000100;
      for (int k = 0; k < 240; k++) begin
         tick();
         n_assert += 2;
         if (dig_sel !== exp_dig) begin n_fail++; $display("FAIL blink dig_sel: got %b expected %b", dig_sel, exp_dig); end
         if (seg_out !== exp_seg) begin n_fail++; $display("FAIL blink seg_out: got %h expected %h dig %b", seg_out, exp_seg, dig_sel); end
         if (dig_sel === 6'b000100 && seg_out === 7'h7F) dark_hits++;
         if (dig_sel === 6'b000100 && seg_out === 7'h19) lit_hits++;
      end
      n_assert += 2;
      if (dark_hits == 0) begin n_fail++; $display("FAIL blink dark phase: got 0 expected >0"); end
      if (lit_hits == 0) begin n_fail++; $display("FAIL blink lit phase: got 0 expected >0"); end
      blink_mask = '0;
   endtask

   task automatic test_enable_reset();
      int guard;
      logic [LN-1:0] ed;
      logic [SN-1:0] es;
      guard = 0;
      while (st % 48 != 29 && guard < 100) begin tick(); guard++; end
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_assert += 3;
         if (dig_sel !== '0) begin n_fail++; $display("FAIL disable dig_sel: got %b expected 000000", dig_sel); end
         if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL disable seg_out: got %h expected 7f", seg_out); end
         if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL disable frame_tick: got %b expected 0", frame_tick); end
      end
      enable = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         ed = (k < 2 || k == 8 || k == 9) ? 6'b000000 : ((k < 8) ? 6'b000001 : 6'b000010);
         es = (k >= 2 && k < 8) ? 7'h40 : ((k == 10) ? 7'h79 : 7'h7F);
         n_assert += 2;
         if (dig_sel !== ed) begin n_fail++; $display("FAIL enable restart dig_sel k=%0d: got %b expected %b", k, dig_sel, ed); end
         if (seg_out !== es) begin n_fail++; $display("FAIL enable restart seg_out k=%0d: got %h expected %h", k, seg_out, es); end
      end
      guard = 0;
      while (st % 8 != 4 && guard < 20) begin tick(); guard++; end
      rst = 1'b1;
      tick();
      n_assert += 3;
      if (dig_sel !== '0) begin n_fail++; $display("FAIL midreset dig_sel: got %b expected 000000", dig_sel); end
      if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL midreset seg_out: got %h expected 7f", seg_out); end
      if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midreset frame_tick: got %b expected 0", frame_tick); end
      rst = 1'b0;
      for (int k = 0; k < 11; k++) begin
         tick();
         ed = (k < 2 || k == 8 || k == 9) ? 6'b000000 : ((k < 8) ? 6'b000001 : 6'b000010);
         es = (k >= 2 && k < 8) ? 7'h40 : ((k == 10) ? 7'h79 : 7'h7F);
         n_assert += 2;
         if (dig_sel !== ed) begin n_fail++; $display("FAIL reset restart dig_sel k=%0d: got %b expected %b", k, dig_sel, ed); end
         if (seg_out !== es) begin n_fail++; $display("FAIL reset restart seg_out k=%0d: got %h expected %h", k, seg_out, es); end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; blink_mask = '0; seg_in = '0;
      test_reset();
      test_routing();
      test_snapshot();
      test_frame_tick();
      test_blink();
      test_enable_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
